pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL provide clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL provide rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL provide load_done, input, 1, program memory loading complete; sampled only in LOAD.
REQ-004 SHALL provide imem_data, input, 12, instruction word read combinationally from program memory at imem_addr.
REQ-005 SHALL provide pc_next, input, 8, next-PC value from the upstream PC-select multiplexer output.
REQ-006 SHALL provide pc_load_en, input, 1, control strobe; commits pc_next in EXECUTE.
REQ-007 SHALL provide stall, input, 1, freeze request; present only with FETCH_STALL_EN.
REQ-008 SHALL provide imem_addr, output, 8, program memory address; equals pc.
REQ-009 SHALL provide pc, output, 8, current program counter.
REQ-010 SHALL provide pc_inc, output, 8, pc+1 modulo 256; the multiplexer's sequential input.
REQ-011 SHALL provide jump_target, output, 8, ir[7:0]; the multiplexer's branch input.
REQ-012 SHALL provide ir, output, 12, instruction register.
REQ-013 SHALL provide ir_valid, output, 1, high for the single DECODE cycle.
REQ-014 SHALL provide stage, output, 2, state encoding LOAD=00, FETCH=01, DECODE=10, EXECUTE=11.

Function
REQ-015 SHALL use four states: LOAD -> FETCH when load_done=1, else stay in LOAD; FETCH -> DECODE; DECODE -> EXECUTE; EXECUTE -> FETCH, all unconditional.
REQ-016 SHALL capture imem_data into ir on the clock edge that leaves FETCH; ir SHALL hold in all other states.
REQ-017 SHALL assert ir_valid combinationally iff stage=DECODE.
REQ-018 SHALL load pc <= pc_next on the edge leaving EXECUTE when pc_load_en=1; SHALL hold pc when pc_load_en=0.
REQ-019 SHALL ignore pc_load_en outside EXECUTE; pc SHALL change only in EXECUTE.
REQ-020 SHALL compute pc_inc as 8-bit pc+1 with wrap: pc=255 gives pc_inc=0, with no carry or flag.
REQ-021 SHALL drive imem_addr, pc_inc, and jump_target combinationally from registered pc and ir, with zero-cycle latency.
REQ-022 SHALL ignore load_done outside LOAD; the block SHALL never return to LOAD except by reset.
REQ-023 SHALL give each instruction a fixed latency of 3 cycles (FETCH, DECODE, EXECUTE).

Reset
REQ-024 On rst=1, at any time including mid-instruction, SHALL asynchronously force stage=LOAD, pc=0, ir=0, and ir_valid=0.
REQ-025 SHALL give the resulting output values during reset: imem_addr=0, pc_inc=1, jump_target=0.
REQ-026 After rst deasserts, SHALL wait in LOAD for load_done.

Configuration
REQ-027 With macro FETCH_STALL_EN defined, SHALL include the stall port: while stall=1 in FETCH, DECODE, or EXECUTE, stage, pc, and ir hold, and ir_valid=0; in LOAD, stall SHALL have no effect.
REQ-028 With FETCH_STALL_EN defined, a stall in EXECUTE SHALL defer the pc_next commit to the first non-stalled EXECUTE edge, using pc_next and pc_load_en as sampled at that edge.
REQ-029 Without FETCH_STALL_EN, the stall port SHALL be absent and behaviour SHALL follow REQ-015 to REQ-023 exactly.

Verification
REQ-030 Reset, then load_done=1 at cycle 3 -> stage 00,00,00,01; imem_addr=0 in FETCH.
REQ-031 Sequential flow: imem_data=12'hA05 at pc=0, pc_next=pc_inc, pc_load_en=1 -> ir=A05 and ir_valid=1 in DECODE; jump_target=05; pc=1 after EXECUTE; next FETCH addresses 1.
REQ-032 Jump: pc_next=jump_target=8'h40 in EXECUTE -> pc=40 and imem_addr=40 in the following FETCH.
REQ-033 Wrap: pc=255 with pc_next=pc_inc -> pc_inc=0 shown before commit; pc=0 after EXECUTE.
REQ-034 Reset asserted during DECODE with pc=7 -> immediate stage=00, pc=0, ir=0, ir_valid=0 before the next edge.
REQ-035 With FETCH_STALL_EN: stall=1 for 2 cycles in EXECUTE with pc_next=9 -> pc unchanged for those 2 cycles, then pc=9 and stage=01 one edge after stall drops.

Source files
------------

// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch -- program counter and instruction fetch sequencer.
//
// Each instruction takes three cycles: FETCH, then DECODE, then EXECUTE.
// The program memory is read combinationally at imem_addr. The word it
// returns is captured into ir on the edge that leaves FETCH. An upstream
// PC-select multiplexer builds pc_next from the pc_inc and jump_target
// outputs. pc_next is committed on the edge that leaves EXECUTE, and only
// when pc_load_en is high.
//
// Optional feature: define FETCH_STALL_EN to add the stall input. While
// stall is high in FETCH, DECODE or EXECUTE, stage, pc and ir are frozen and
// ir_valid is low. A stalled EXECUTE commits pc_next on the first edge where
// stall is low. stall has no effect in LOAD.
// ---------------------------------------------------------------------------
module pc_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_done,
    input  logic [11:0] imem_data,
    input  logic [7:0]  pc_next,
    input  logic        pc_load_en,
`ifdef FETCH_STALL_EN
    input  logic        stall,
`endif
    output logic [7:0]  imem_addr,
    output logic [7:0]  pc,
    output logic [7:0]  pc_inc,
    output logic [7:0]  jump_target,
    output logic [11:0] ir,
    output logic        ir_valid,
    output logic [1:0]  stage
);

    // The encoding is visible on the stage port, so it is fixed here.
    typedef enum logic [1:0] {
        ST_LOAD    = 2'b00,
        ST_FETCH   = 2'b01,
        ST_DECODE  = 2'b10,
        ST_EXECUTE = 2'b11
    } state_t;

    state_t      r_state;
    logic [7:0]  r_pc;
    logic [11:0] r_ir;

    logic        w_hold;
    logic [7:0]  w_pc_inc;

`ifdef FETCH_STALL_EN
    // A stall freezes the instruction pipeline. It is ignored in LOAD so
    // that start-up cannot be blocked by it.
    assign w_hold = stall && (r_state != ST_LOAD);
`else
    assign w_hold = 1'b0;
`endif

    // The sum is 8 bits wide, so the carry out of bit 7 is dropped and
    // pc=255 gives pc_inc=0.
    assign w_pc_inc = r_pc + 8'd1;

    // Sequencer state, pc and ir, all updated together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
            r_pc    <= 8'h00;
            r_ir    <= 12'h000;
        end else if (!w_hold) begin
            case (r_state)
                ST_LOAD: begin
                    if (load_done) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_ir    <= imem_data;
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (pc_load_en) begin
                        r_pc <= pc_next;
                    end
                    r_state <= ST_FETCH;
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    // These outputs have zero-cycle latency from the registered pc and ir.
    assign pc          = r_pc;
    assign imem_addr   = r_pc;
    assign pc_inc      = w_pc_inc;
    assign ir          = r_ir;
    assign jump_target = r_ir[7:0];
    assign stage       = r_state;
    assign ir_valid    = (r_state == ST_DECODE) && !w_hold;

endmodule

// File: tb/tb_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch -- directed bench for pc_fetch.
// Build with +define+FETCH_STALL_EN to also exercise the stall port.
// ---------------------------------------------------------------------------
module tb_pc_fetch;

    logic        clk;
    logic        rst;
    logic        load_done;
    logic [11:0] imem_data;
    logic [7:0]  pc_next;
    logic        pc_load_en;
    logic        stall;
    logic [7:0]  imem_addr;
    logic [7:0]  pc;
    logic [7:0]  pc_inc;
    logic [7:0]  jump_target;
    logic [11:0] ir;
    logic        ir_valid;
    logic [1:0]  stage;

    logic [11:0] mem [256];
    int          sel_mode;
    int          n_cmp;
    int          n_err;

    pc_fetch u_dut (
        .clk         (clk),
        .rst         (rst),
        .load_done   (load_done),
        .imem_data   (imem_data),
        .pc_next     (pc_next),
        .pc_load_en  (pc_load_en),
`ifdef FETCH_STALL_EN
        .stall       (stall),
`endif
        .imem_addr   (imem_addr),
        .pc          (pc),
        .pc_inc      (pc_inc),
        .jump_target (jump_target),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .stage       (stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational program memory.
    assign imem_data = mem[imem_addr];

    // Stand-in for the upstream PC-select mux: 0 = sequential, 1 = branch,
    // 2 = fixed address 9.
    always_comb begin
        pc_next = pc_inc;
        case (sel_mode)
            1:       pc_next = jump_target;
            2:       pc_next = 8'h09;
            default: pc_next = pc_inc;
        endcase
    end

    task automatic check_val(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and sample on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        sel_mode   = 0;
        stall      = 1'b0;
        load_done  = 1'b0;
        pc_load_en = 1'b0;
        rst        = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 12'h000;
        mem[8'h00] = 12'hA05;
        mem[8'h01] = 12'h340;
        mem[8'h05] = 12'h807;
        mem[8'h40] = 12'hAFF;
        mem[8'hFF] = 12'h123;

        // Values while reset is held.
        #2;
        check_val("rst_stage",   16'(stage),       16'h0);
        check_val("rst_pc",      16'(pc),          16'h00);
        check_val("rst_ir",      16'(ir),          16'h000);
        check_val("rst_irv",     16'(ir_valid),    16'h0);
        check_val("rst_addr",    16'(imem_addr),   16'h00);
        check_val("rst_pcinc",   16'(pc_inc),      16'h01);
        check_val("rst_jt",      16'(jump_target), 16'h00);

        // Stay in LOAD until load_done is seen.
        @(negedge clk);
        rst = 1'b0;
        check_val("load_c0", 16'(stage), 16'h0);
        step();
        check_val("load_c1", 16'(stage), 16'h0);
        step();
        check_val("load_c2", 16'(stage), 16'h0);
        load_done = 1'b1;
        step();
        check_val("load_c3", 16'(stage), 16'h1);
        check_val("fetch0_addr", 16'(imem_addr), 16'h00);
        load_done = 1'b0;

        // Sequential flow from address 0.
        pc_load_en = 1'b1;
        sel_mode   = 0;
        step();
        check_val("seq_dec_stage", 16'(stage),       16'h2);
        check_val("seq_dec_ir",    16'(ir),          16'hA05);
        check_val("seq_dec_irv",   16'(ir_valid),    16'h1);
        check_val("seq_dec_jt",    16'(jump_target), 16'h05);
        step();
        check_val("seq_ex_stage",  16'(stage),    16'h3);
        check_val("seq_ex_irv",    16'(ir_valid), 16'h0);
        check_val("seq_ex_pc",     16'(pc),       16'h00);
        step();
        check_val("seq_f_stage",   16'(stage),     16'h1);
        check_val("seq_f_pc",      16'(pc),        16'h01);
        check_val("seq_f_addr",    16'(imem_addr), 16'h01);

        // Branch to 0x40.
        sel_mode = 1;
        step();
        check_val("jmp_dec_jt", 16'(jump_target), 16'h40);
        step();
        step();
        check_val("jmp_f_pc",   16'(pc),        16'h40);
        check_val("jmp_f_addr", 16'(imem_addr), 16'h40);

        // pc_load_en and load_done must be ignored outside EXECUTE and LOAD.
        load_done = 1'b1;
        step();
        check_val("ign_dec_pc",    16'(pc),    16'h40);
        check_val("ign_dec_stage", 16'(stage), 16'h2);
        step();
        check_val("ign_ex_pc",     16'(pc),    16'h40);
        check_val("ign_ex_stage",  16'(stage), 16'h3);
        pc_load_en = 1'b0;
        step();
        check_val("hold_f_pc",     16'(pc),    16'h40);
        check_val("hold_f_stage",  16'(stage), 16'h1);
        load_done = 1'b0;

        // Branch to 0xFF, then step sequentially and wrap to 0.
        pc_load_en = 1'b1;
        step();
        check_val("ff_dec_ir", 16'(ir), 16'hAFF);
        step();
        step();
        check_val("ff_f_pc",    16'(pc),     16'hFF);
        check_val("ff_f_pcinc", 16'(pc_inc), 16'h00);
        sel_mode = 0;
        step();
        step();
        check_val("wrap_ex_pcinc", 16'(pc_inc), 16'h00);
        check_val("wrap_ex_pc",    16'(pc),     16'hFF);
        step();
        check_val("wrap_f_pc",   16'(pc),        16'h00);
        check_val("wrap_f_addr", 16'(imem_addr), 16'h00);

        // Branch 0 -> 5 -> 7, then reset while in DECODE.
        sel_mode = 1;
        step();
        step();
        step();
        check_val("to5_pc", 16'(pc), 16'h05);
        step();
        step();
        step();
        check_val("to7_pc", 16'(pc), 16'h07);
        step();
        check_val("pre_rst_stage", 16'(stage),    16'h2);
        check_val("pre_rst_irv",   16'(ir_valid), 16'h1);
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_stage", 16'(stage),       16'h0);
        check_val("mid_rst_pc",    16'(pc),          16'h00);
        check_val("mid_rst_ir",    16'(ir),          16'h000);
        check_val("mid_rst_irv",   16'(ir_valid),    16'h0);
        check_val("mid_rst_addr",  16'(imem_addr),   16'h00);
        check_val("mid_rst_pcinc", 16'(pc_inc),      16'h01);
        check_val("mid_rst_jt",    16'(jump_target), 16'h00);
        @(negedge clk);
        rst        = 1'b0;
        pc_load_en = 1'b0;
        step();
        check_val("post_rst_wait", 16'(stage), 16'h0);
        load_done = 1'b1;
        step();
        check_val("post_rst_fetch", 16'(stage), 16'h1);
        load_done = 1'b0;

`ifdef FETCH_STALL_EN
        // A stall in FETCH holds the stage and does not capture ir.
        stall = 1'b1;
        step();
        check_val("stl_f_stage", 16'(stage), 16'h1);
        check_val("stl_f_ir",    16'(ir),    16'h000);
        stall = 1'b0;
        step();
        check_val("stl_d_ir", 16'(ir), 16'hA05);
        // A stall in DECODE drops ir_valid and holds the stage.
        stall = 1'b1;
        #1;
        check_val("stl_d_irv", 16'(ir_valid), 16'h0);
        step();
        check_val("stl_d_stage", 16'(stage), 16'h2);
        stall = 1'b0;
        step();
        check_val("stl_e_stage", 16'(stage), 16'h3);
        // A stall in EXECUTE defers the commit of pc_next = 9.
        stall      = 1'b1;
        sel_mode   = 2;
        pc_load_en = 1'b1;
        step();
        check_val("stl_e1_pc",    16'(pc),    16'h00);
        check_val("stl_e1_stage", 16'(stage), 16'h3);
        step();
        check_val("stl_e2_pc",    16'(pc),    16'h00);
        check_val("stl_e2_stage", 16'(stage), 16'h3);
        stall = 1'b0;
        step();
        check_val("stl_rel_pc",    16'(pc),    16'h09);
        check_val("stl_rel_stage", 16'(stage), 16'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
